pipelined_subtractor46_12: RTL and testbench



---
 rtl/arith_widths_pkg.sv | 10 +
 rtl/subtract_slice.sv | 19 +
 rtl/pipelined_subtractor46_12.sv | 108 ++++++++++
 tb/tb_pipelined_subtractor46_12.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_widths_pkg.sv
// Shared widths and word type for the 46-bit accumulator add/subtract datapaths.
package arith_widths_pkg;

    localparam int WIDTH_A = 46;
    localparam int WIDTH_B = 34;
    localparam int SPLIT   = 23;

    typedef logic [WIDTH_A-1:0] acc_word_t;

endpackage

// File: rtl/subtract_slice.sv
// Combinational N-bit subtract with borrow-in and borrow-out: d = x - y - bin.
module subtract_slice #(
    parameter int N = 23
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         bin,
    output logic [N-1:0] d,
    output logic         bout
);

    logic [N:0] full;

    // The extra top bit of the widened difference is the borrow out.
    assign full = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bin};
    assign d    = full[N-1:0];
    assign bout = full[N];

endmodule

// File: rtl/pipelined_subtractor46_12.sv
// Two-stage subtractor a - zext(b) with the borrow chain split at SPLIT and valid/ready flow control.
module pipelined_subtractor46_12
    import arith_widths_pkg::*;
#(
    parameter int WIDTH_A = arith_widths_pkg::WIDTH_A,
    parameter int WIDTH_B = arith_widths_pkg::WIDTH_B,
    parameter int SPLIT   = arith_widths_pkg::SPLIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_A-1:0] a,
    input  logic [WIDTH_B-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_A-1:0] diff,
    output logic               borrow
);

    localparam int HI_W = WIDTH_A - SPLIT;

    logic [WIDTH_A-1:0] b_ext;
    logic [SPLIT-1:0]   lo_p0;
    logic               b1_p0;
    logic [HI_W-1:0]    hi_p1;
    logic               bout_p1;

    logic [SPLIT-1:0]   lo_p1;
    logic               b1_p1;
    logic [HI_W-1:0]    a_hi_p1;
    logic [HI_W-1:0]    b_hi_p1;
    logic               vld_p1;

    logic [WIDTH_A-1:0] diff_p2;
    logic               borrow_p2;
    logic               vld_p2;

    logic s2_free;
    logic advance;
    logic accept;

    assign b_ext = {{(WIDTH_A-WIDTH_B){1'b0}}, b};

    assign s2_free  = !vld_p2 || out_ready;
    assign advance  = vld_p1 && s2_free;
    assign in_ready = !vld_p1 || s2_free;
    assign accept   = in_valid && in_ready;

    // Stage 1: low SPLIT-bit borrow chain
    subtract_slice #(.N(SPLIT)) u_lo (
        .x    (a[SPLIT-1:0]),
        .y    (b_ext[SPLIT-1:0]),
        .bin  (1'b0),
        .d    (lo_p0),
        .bout (b1_p0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            lo_p1   <= '0;
            b1_p1   <= 1'b0;
            a_hi_p1 <= '0;
            b_hi_p1 <= '0;
        end else begin
            if (accept) begin
                vld_p1  <= 1'b1;
                lo_p1   <= lo_p0;
                b1_p1   <= b1_p0;
                a_hi_p1 <= a[WIDTH_A-1:SPLIT];
                b_hi_p1 <= b_ext[WIDTH_A-1:SPLIT];
            end else if (advance) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    // Stage 2: high chain consumes the stage-1 borrow
    subtract_slice #(.N(HI_W)) u_hi (
        .x    (a_hi_p1),
        .y    (b_hi_p1),
        .bin  (b1_p1),
        .d    (hi_p1),
        .bout (bout_p1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            diff_p2   <= '0;
            borrow_p2 <= 1'b0;
        end else begin
            if (advance) begin
                vld_p2    <= 1'b1;
                diff_p2   <= {hi_p1, lo_p1};
                borrow_p2 <= bout_p1;
            end else if (out_ready) begin
                vld_p2    <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p2;
    assign diff      = diff_p2;
    assign borrow    = borrow_p2;

endmodule

// File: tb/tb_pipelined_subtractor46_12.sv
// Scoreboard bench for pipelined_subtractor46_12: directed vectors, backpressure, streaming, mid-flight reset.
module tb_pipelined_subtractor46_12;
    import arith_widths_pkg::*;

    typedef struct {
        acc_word_t d;
        logic      bw;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    acc_word_t   a;
    logic [33:0] b;
    logic        out_valid;
    logic        out_ready;
    acc_word_t   diff;
    logic        borrow;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic stream_on = 1'b0;
    int   stream_rx = 0;
    int   stream_gap = 0;

    pipelined_subtractor46_12 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic send(input acc_word_t av, input logic [33:0] bv,
                        input acc_word_t ed, input logic eb);
        int waited;
        exp_t e;
        waited = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        #1;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #3;
            waited++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
        end else begin
            e.d  = ed;
            e.bw = eb;
            sb.push_back(e);
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got diff 0x%0h borrow %0b, required no output", diff, borrow);
            end else begin
                e = sb.pop_front();
                chk("diff", 64'(diff), 64'(e.d));
                chk("borrow", 64'(borrow), 64'(e.bw));
                if (stream_on) stream_rx++;
            end
        end
        if (stream_on && stream_rx > 0 && stream_rx < 100 && !out_valid) stream_gap++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_word_t ra;
        logic [33:0] rb;
        logic [46:0] full;

        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_borrow", 64'(borrow), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        idle(1);

        // Directed vectors with latency probe on the first.
        out_ready = 1'b1;
        send(46'h3FFF_FFFF_FFFF, 34'h1, 46'h3FFF_FFFF_FFFE, 1'b0);
        #1;
        chk("lat_after_accept", 64'(out_valid), 64'd0);
        @(posedge clk);
        #3;
        chk("lat_result_ready", 64'(out_valid), 64'd1);
        idle(1);
        send(46'h0000_0080_0000, 34'h1, 46'h0000_007F_FFFF, 1'b0);
        send(46'h0, 34'h3_FFFF_FFFF, 46'h3FFC_0000_0001, 1'b1);
        send(46'h2_AAAA_AAAA, 34'h2_AAAA_AAAA, 46'h0, 1'b0);
        send(46'h5, 34'h7, 46'h3FFF_FFFF_FFFE, 1'b1);
        idle(4);
        chk("directed_drained", 64'(sb.size()), 64'd0);

        // Backpressure: two accepted, then stall with op1 held at the output.
        out_ready = 1'b0;
        send(46'd100, 34'd1, 46'd99, 1'b0);
        send(46'h5, 34'h7, 46'h3FFF_FFFF_FFFE, 1'b1);
        in_valid = 1'b1;
        a = 46'h1234;
        b = 34'h34;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_diff_hold", 64'(diff), 64'd99);
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        send(46'h1234, 34'h34, 46'h1200, 1'b0);
        send(46'h3FFF_FFFF_FFFF, 34'h3_FFFF_FFFF, 46'h3FFC_0000_0000, 1'b0);
        send(46'h10_0000_0000, 34'h2_0000_0000, 46'hE_0000_0000, 1'b0);
        idle(4);
        chk("bp_drained", 64'(sb.size()), 64'd0);

        // Streaming: 100 random operands back to back.
        stream_on = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            full = {1'b0, ra} - {13'd0, rb};
            send(ra, rb, full[45:0], full[46]);
        end
        idle(4);
        stream_on = 1'b0;
        chk("stream_count", 64'(stream_rx), 64'd100);
        chk("stream_gaps", 64'(stream_gap), 64'd0);
        chk("stream_drained", 64'(sb.size()), 64'd0);

        // Reset with two operations in flight, asserted between edges.
        out_ready = 1'b0;
        send(46'h1111, 34'h11, 46'h1100, 1'b0);
        send(46'h2222, 34'h22, 46'h2200, 1'b0);
        #1;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_diff", 64'(diff), 64'd0);
        chk("midrst_borrow", 64'(borrow), 64'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        #1;
        chk("after_rst_in_ready", 64'(in_ready), 64'd1);
        chk("after_rst_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        idle(6);
        send(46'h3000_0000_0000, 34'h1_0000_0001, 46'h2FFF_0000_0000 - 46'h1 + 46'h1_0000_0000 - 46'h1_0000_0000 + 46'h0, 1'b0);
        idle(4);
        chk("final_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
